gsim_mat_mem_resp: RTL and testbench
====================================

// Module: gsim_mat_mem_resp
// PURPOSE
//   Responder end of the matrix-memory read interface used by the GSIM solver.
//   Accepts read requests (rreq/addr, qualified by rrdy), fetches 256-bit rows from a
//   single-port SRAM macro and returns them with dout_vld after a fixed latency.
//   Also provides a preload write port for loading matrices before a solve.
//   A configurable pacing gap exercises initiator flow control.
// PARAMETERS
//   ADDR_W   10   address width (1024 rows)
//   DATA_W   256  row width (16 x 16-bit entries)
//   LAT      2    cycles from accept cycle to dout_vld; legal range 2..8
//   RRDY_GAP 0    cycles o_rrdy is held low after each accepted read; 0 = one accept/cycle
// PORTS
//   i_clk        in   1       clock, rising edge
//   i_rst_n      in   1       asynchronous active-low reset
//   i_rreq       in   1       read request, held by the initiator until accepted
//   i_addr       in   ADDR_W  read row address, sampled on accept
//   o_rrdy       out  1       responder can accept this cycle
//   o_dout       out  DATA_W  read data, valid only when o_dout_vld=1
//   o_dout_vld   out  1       one-cycle pulse per accepted read
//   o_err        out  1       out-of-range flag, qualified by o_dout_vld
//   i_limit      in   ADDR_W  exclusive upper bound of legal addresses (e.g. 17*matrix_num)
//   i_wen        in   1       preload write strobe
//   i_waddr      in   ADDR_W  preload write address
//   i_wdata      in   DATA_W  preload write data
//   o_sram_cen   out  1       SRAM chip enable, active low
//   o_sram_wen   out  1       SRAM write enable, active low (1 = read)
//   o_sram_a     out  ADDR_W  SRAM address
//   o_sram_d     out  DATA_W  SRAM write data
//   i_sram_q     in   DATA_W  SRAM read data, valid 1 cycle after a read access
// BEHAVIOUR
//   - Reset (async, i_rst_n=0): state=READY, gap counter=0, all pipeline valids cleared,
//     o_dout=0, o_dout_vld=0, o_err=0. While reset is low: o_rrdy=0, o_sram_cen=1.
//     In-flight reads are dropped and never produce dout_vld.
//   - FSM: READY and GAP.
//     o_rrdy = (state==READY) & ~i_wen & i_rst_n. This is combinational from i_wen.
//     accept = i_rreq & o_rrdy.
//     READY -> GAP on accept when RRDY_GAP>0 (load cnt=RRDY_GAP-1).
//     GAP: decrement cnt each cycle; return to READY in the cycle after cnt==0.
//   - SRAM port (combinational), priority write > read > idle:
//     * i_wen: cen=0, wen=0, a=i_waddr, d=i_wdata. Writes are accepted in any state.
//     * accept with i_addr<i_limit: cen=0, wen=1, a=i_addr.
//     * otherwise: cen=1, wen=1, a=0, d=0.
//   - Read pipeline: a valid/err token enters at accept.
//     * i_sram_q is captured in the cycle after accept.
//     * The token is delayed so o_dout_vld rises exactly LAT cycles after the accept cycle.
//       o_dout and o_err are registered and aligned with it.
//     * Throughput is one read/cycle when RRDY_GAP=0. Order is strictly preserved.
//   - Out-of-range (i_addr>=i_limit): no SRAM access. Returned with o_dout=0, o_err=1,
//     same latency. o_err=0 for in-range reads.
//   - i_limit is sampled at accept. Changes after accept do not affect in-flight reads.
//   - o_dout holds its last value when o_dout_vld=0. o_err is 0 whenever o_dout_vld=0.
//   - Simultaneous i_wen and i_rreq: the write wins and the read is not accepted.
//     The initiator keeps i_rreq/i_addr, and the read is accepted the next eligible cycle.
//   - Write to an address with a read already accepted: the read returns the pre-write
//     data, because the SRAM access happened at accept.
//   - GAP counter does not wrap. i_rreq during GAP is ignored (no accept, no state change).
// TESTING
//   1. LAT=2,GAP=0: write row5=A, row6=B, row7=C; then rreq 5,6,7 back-to-back
//      -> dout_vld at accept+2,+3,+4 with A,B,C, err=0.
//   2. GAP=3: i_rreq held high for 12 cycles -> accepts in cycles 0,4,8; o_rrdy low 1-3,5-7,9-11.
//   3. i_limit=34: read 33 -> normal data, err=0; read 34 -> dout=0, err=1, o_sram_cen stays 1.
//   4. i_wen(row9=D) and i_rreq(addr 9) in the same cycle -> o_rrdy=0, write done;
//      accepted next cycle, returns D.
//   5. Read row9 (old=E) accepted, i_wen row9=F next cycle -> returned data E.
//   6. LAT=4: reset pulsed 2 cycles after accept -> no dout_vld ever; outputs 0;
//      o_rrdy=1 after release.

Source files
------------

// File: rtl/gsim_mat_mem_resp.sv
// Matrix-memory read responder: accepts row reads, fetches them from a single-port SRAM
// and returns data with a fixed latency; also forwards preload writes to the SRAM.
module gsim_mat_mem_resp #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 256,
  parameter int LAT      = 2,
  parameter int RRDY_GAP = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rreq,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_rrdy,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_dout_vld,
  output logic              o_err,
  input  logic [ADDR_W-1:0] i_limit,
  input  logic              i_wen,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_sram_cen,
  output logic              o_sram_wen,
  output logic [ADDR_W-1:0] o_sram_a,
  output logic [DATA_W-1:0] o_sram_d,
  input  logic [DATA_W-1:0] i_sram_q
);

  typedef enum logic {ST_READY, ST_GAP} state_t;

  localparam int CNT_W = (RRDY_GAP > 2) ? $clog2(RRDY_GAP) : 1;
  localparam int VD    = LAT - 1;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_accept;
  logic              w_in_range;
  logic [VD-1:0]     r_vld;
  logic [VD-1:0]     r_err;
  logic [DATA_W-1:0] w_rd;
  logic [DATA_W-1:0] w_tail_d;

  // Handshake: a read is accepted in any cycle where i_rreq and o_rrdy are both high.
  assign o_rrdy     = (r_state == ST_READY) & ~i_wen & i_rst_n;
  assign w_accept   = i_rreq & o_rrdy;
  assign w_in_range = (i_addr < i_limit);

  always_comb begin
    o_sram_cen = 1'b1;
    o_sram_wen = 1'b1;
    o_sram_a   = '0;
    o_sram_d   = '0;
    if (!i_rst_n) begin
      o_sram_cen = 1'b1;
    end else if (i_wen) begin
      o_sram_cen = 1'b0;
      o_sram_wen = 1'b0;
      o_sram_a   = i_waddr;
      o_sram_d   = i_wdata;
    end else if (w_accept && w_in_range) begin
      o_sram_cen = 1'b0;
      o_sram_a   = i_addr;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_READY;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_READY: begin
          if (w_accept && (RRDY_GAP != 0)) begin
            r_state <= ST_GAP;
            r_cnt   <= CNT_W'(RRDY_GAP - 1);
          end
        end
        ST_GAP: begin
          if (r_cnt == '0) r_state <= ST_READY;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        default: r_state <= ST_READY;
      endcase
    end
  end

  // Token stage k holds the read accepted k+1 cycles ago; stage 0 sees i_sram_q.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= '0;
      r_err <= '0;
    end else begin
      r_vld[0] <= w_accept;
      r_err[0] <= w_accept & ~w_in_range;
      for (int k = 1; k < VD; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_err[k] <= r_err[k-1];
      end
    end
  end

  assign w_rd = r_err[0] ? '0 : i_sram_q;

  generate
    if (LAT == 2) begin : g_direct
      assign w_tail_d = w_rd;
    end else begin : g_delay
      logic [DATA_W-1:0] r_d [LAT-2];
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int k = 0; k < LAT - 2; k++) r_d[k] <= '0;
        end else begin
          r_d[0] <= w_rd;
          for (int k = 1; k < LAT - 2; k++) r_d[k] <= r_d[k-1];
        end
      end
      assign w_tail_d = r_d[LAT-3];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dout     <= '0;
      o_dout_vld <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_dout_vld <= r_vld[VD-1];
      o_err      <= r_vld[VD-1] & r_err[VD-1];
      if (r_vld[VD-1]) o_dout <= w_tail_d;
    end
  end

endmodule

// File: tb/tb_gsim_mat_mem_resp.sv
// Bench for gsim_mat_mem_resp: main instance (LAT=2, no gap) with SRAM model and
// scoreboard, plus a gap-pacing instance and a LAT=4 reset-flush instance.
module tb_gsim_mat_mem_resp;
  localparam int AW = 10;
  localparam int DW = 256;

  localparam logic [DW-1:0] PAT_A = {16{16'h1A1A}};
  localparam logic [DW-1:0] PAT_B = {16{16'h2B2B}};
  localparam logic [DW-1:0] PAT_C = {16{16'h3C3C}};
  localparam logic [DW-1:0] PAT_D = {16{16'h4D4D}};
  localparam logic [DW-1:0] PAT_E = {16{16'h5E5E}};
  localparam logic [DW-1:0] PAT_F = {16{16'h6F6F}};
  localparam logic [DW-1:0] PAT_G = {16{16'h7777}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- main instance: LAT=2, RRDY_GAP=0 ----------------
  logic          m_rst_n = 1'b0, m_rreq = 1'b0, m_wen = 1'b0;
  logic [AW-1:0] m_addr = '0, m_limit = 10'd1023, m_waddr = '0;
  logic [DW-1:0] m_wdata = '0, m_sram_q = '0;
  logic          m_rrdy, m_vld, m_err, m_cen, m_swen;
  logic [DW-1:0] m_dout, m_sd;
  logic [AW-1:0] m_sa;

  gsim_mat_mem_resp #(.ADDR_W(AW), .DATA_W(DW), .LAT(2), .RRDY_GAP(0)) u_dut (
    .i_clk(clk), .i_rst_n(m_rst_n), .i_rreq(m_rreq), .i_addr(m_addr), .o_rrdy(m_rrdy),
    .o_dout(m_dout), .o_dout_vld(m_vld), .o_err(m_err), .i_limit(m_limit), .i_wen(m_wen),
    .i_waddr(m_waddr), .i_wdata(m_wdata), .o_sram_cen(m_cen), .o_sram_wen(m_swen),
    .o_sram_a(m_sa), .o_sram_d(m_sd), .i_sram_q(m_sram_q));

  logic [DW-1:0] m_mem [1024];
  always @(posedge clk) begin
    if (!m_cen) begin
      if (!m_swen) m_mem[m_sa] <= m_sd;
      else         m_sram_q <= m_mem[m_sa];
    end
  end

  logic [DW:0] exp_q[$];
  int          exp_cyc_q[$];

  always @(negedge clk) begin
    if (m_rst_n) begin
      if (m_vld) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_dout_vld", 1, 0);
        end else begin
          chk("dout_err", {m_err, m_dout}, exp_q.pop_front());
          chk("latency_cycle", (DW+1)'(cyc), (DW+1)'(exp_cyc_q.pop_front()));
        end
      end else begin
        chk("err_without_vld", (DW+1)'(m_err), 0);
      end
    end
  end

  task automatic m_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    m_rreq = 1'b0; m_wen = 1'b1; m_waddr = a; m_wdata = d;
  endtask

  task automatic m_idle();
    @(negedge clk);
    m_rreq = 1'b0; m_wen = 1'b0;
  endtask

  task automatic m_read(input logic [AW-1:0] a, input logic e, input logic [DW-1:0] d);
    int n = 0;
    @(negedge clk);
    m_wen = 1'b0; m_rreq = 1'b1; m_addr = a;
    #1;
    while (!m_rrdy && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (m_rrdy) begin
      exp_q.push_back({e, d});
      exp_cyc_q.push_back(cyc + 2);
      chk("sram_cen_on_read", (DW+1)'(m_cen), (DW+1)'(e));
      if (!e) chk("sram_addr_on_read", (DW+1)'({m_swen, m_sa}), (DW+1)'({1'b1, a}));
    end else begin
      chk("accept_timeout", 1, 0);
    end
  endtask

  // ---------------- gap instance: RRDY_GAP=3 ----------------
  logic          g_rst_n = 1'b0, g_rreq = 1'b0, g_rrdy, g_vld, g_err, g_cen, g_swen;
  logic [DW-1:0] g_dout, g_sd;
  logic [AW-1:0] g_sa;
  logic [AW-1:0] g_zero_a = '0, g_lim = 10'd100;
  logic [DW-1:0] g_zero_d = '0;
  logic          g_zero = 1'b0;

  gsim_mat_mem_resp #(.ADDR_W(AW), .DATA_W(DW), .LAT(2), .RRDY_GAP(3)) u_gap (
    .i_clk(clk), .i_rst_n(g_rst_n), .i_rreq(g_rreq), .i_addr(g_zero_a), .o_rrdy(g_rrdy),
    .o_dout(g_dout), .o_dout_vld(g_vld), .o_err(g_err), .i_limit(g_lim), .i_wen(g_zero),
    .i_waddr(g_zero_a), .i_wdata(g_zero_d), .o_sram_cen(g_cen), .o_sram_wen(g_swen),
    .o_sram_a(g_sa), .o_sram_d(g_sd), .i_sram_q(g_zero_d));

  // ---------------- LAT=4 instance ----------------
  logic          l_rst_n = 1'b0, l_rreq = 1'b0, l_rrdy, l_vld, l_err, l_cen, l_swen;
  logic [DW-1:0] l_dout, l_sd, l_q = '1;
  logic [AW-1:0] l_sa, l_addr = 10'd1, l_lim = 10'd10;

  gsim_mat_mem_resp #(.ADDR_W(AW), .DATA_W(DW), .LAT(4), .RRDY_GAP(0)) u_lat4 (
    .i_clk(clk), .i_rst_n(l_rst_n), .i_rreq(l_rreq), .i_addr(l_addr), .o_rrdy(l_rrdy),
    .o_dout(l_dout), .o_dout_vld(l_vld), .o_err(l_err), .i_limit(l_lim), .i_wen(g_zero),
    .i_waddr(g_zero_a), .i_wdata(g_zero_d), .o_sram_cen(l_cen), .o_sram_wen(l_swen),
    .o_sram_a(l_sa), .o_sram_d(l_sd), .i_sram_q(l_q));

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rrdy", (DW+1)'(m_rrdy), 0);
    chk("rst_cen", (DW+1)'(m_cen), 1);
    chk("rst_out", {m_vld, m_err, m_dout}, 0);
    @(negedge clk);
    m_rst_n = 1'b1; g_rst_n = 1'b1; l_rst_n = 1'b1;
    #1;
    chk("rrdy_after_rst", (DW+1)'(m_rrdy), 1);

    // Preload then back-to-back reads
    m_write(5, PAT_A); m_write(6, PAT_B); m_write(7, PAT_C);
    m_read(5, 1'b0, PAT_A); m_read(6, 1'b0, PAT_B); m_read(7, 1'b0, PAT_C);
    m_idle();

    // Limit boundary; limit raised after accept must not affect the in-flight read
    m_limit = 10'd34;
    m_write(33, PAT_G);
    m_read(33, 1'b0, PAT_G);
    m_read(34, 1'b1, '0);
    @(posedge clk); #1;
    m_limit = 10'd100;
    m_idle();

    // Write and read collide: write wins, read accepted next cycle
    @(negedge clk);
    m_wen = 1'b1; m_waddr = 9; m_wdata = PAT_D; m_rreq = 1'b1; m_addr = 9;
    #1;
    chk("collide_rrdy", (DW+1)'(m_rrdy), 0);
    chk("collide_write", (DW+1)'({m_cen, m_swen, m_sa}), (DW+1)'({2'b00, 10'd9}));
    @(negedge clk);
    m_wen = 1'b0;
    #1;
    chk("collide_rrdy_next", (DW+1)'(m_rrdy), 1);
    exp_q.push_back({1'b0, PAT_D});
    exp_cyc_q.push_back(cyc + 2);
    m_idle();

    // Write after accepted read returns old data
    m_write(9, PAT_E);
    m_read(9, 1'b0, PAT_E);
    m_write(9, PAT_F);
    m_read(9, 1'b0, PAT_F);
    m_idle();

    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
    chk("scoreboard_drain", (DW+1)'(exp_q.size()), 0);

    // Pacing gap: rrdy high only every fourth cycle while rreq held
    @(negedge clk);
    g_rreq = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      chk($sformatf("gap_rrdy_c%0d", k), (DW+1)'(g_rrdy), (DW+1)'(k % 4 == 0));
      @(negedge clk);
    end
    g_rreq = 1'b0;

    // LAT=4 latency
    @(negedge clk);
    l_rreq = 1'b1;
    #1;
    chk("lat4_accept", (DW+1)'(l_rrdy), 1);
    @(negedge clk);
    l_rreq = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      #1;
      chk($sformatf("lat4_vld_c%0d", k), (DW+1)'(l_vld), (DW+1)'(k == 4));
      if (k == 4) chk("lat4_data", {l_err, l_dout}, {1'b0, PAT_F ^ PAT_F ^ {DW{1'b1}}});
      @(negedge clk);
    end

    // LAT=4 reset flush of an in-flight read
    l_rreq = 1'b1;
    #1;
    chk("flush_accept", (DW+1)'(l_rrdy), 1);
    @(negedge clk);
    l_rreq = 1'b0;
    @(negedge clk);
    l_rst_n = 1'b0;
    #1;
    chk("flush_rrdy_in_rst", (DW+1)'(l_rrdy), 0);
    chk("flush_cen_in_rst", (DW+1)'(l_cen), 1);
    repeat (2) @(negedge clk);
    l_rst_n = 1'b1;
    #1;
    chk("flush_rrdy_after", (DW+1)'(l_rrdy), 1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("flush_out_c%0d", k), {l_vld, l_err, l_dout[DW-2:0]}, 0);
      @(negedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
